spi_slave_regfile: RTL and testbench

- 3-wire SPI target that terminates frames issued by the team's SPI master (spi_mt) and exposes a small register file.
- Oversamples sclk, cs and sdio on its own system clock. Decodes R/W bit, address and data, and drives read data back on the shared sdio line.
- Provides a local parallel read port and a write-strobe interface for downstream logic.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_regfile.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by spi_slave_regfile and the spi_mt master.
// Holds the frame state encoding, the R/W bit values and the default field widths.
package spi_pkg;

  localparam int SPI_A_WIDTH = 8;
  localparam int SPI_D_WIDTH = 16;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter logic reset_val = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= reset_val;
      q    <= reset_val;
      prev <= reset_val;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// 3-wire SPI target with a small register file, oversampling sclk/cs/sdio on clk.
// Define SPI_ADDR_AUTOINC_EN to allow multi-word bursts with auto-incrementing address.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int a_width  = SPI_A_WIDTH,
  parameter int d_width  = SPI_D_WIDTH,
  parameter int num_regs = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  inout  wire                sdio,
  input  logic [a_width-1:0] lcl_addr,
  output logic [d_width-1:0] lcl_rdata,
  output logic               wr_stb,
  output logic [a_width-1:0] wr_addr,
  output logic [d_width-1:0] wr_data,
  output logic               busy,
  output logic               frame_err
);

  localparam int IW = $clog2(num_regs);
  localparam int CW = $clog2(((a_width > d_width) ? a_width : d_width) + 1);
  localparam logic [CW-1:0] CNT_A = CW'(a_width);
  localparam logic [CW-1:0] CNT_D = CW'(d_width);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sdi_meta, sdi;

  spi_sync_edge #(.reset_val(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.reset_val(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdi_meta <= 1'b0;
      sdi      <= 1'b0;
    end else begin
      sdi_meta <= sdio;
      sdi      <= sdi_meta;
    end
  end

  spi_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [d_width-1:0]  shift_q, shift_d;
  logic [a_width-1:0]  addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                oe_q, oe_d;
  logic                sdo_q, sdo_d;
  logic                err_d;
  logic                stb_d;
  logic [a_width-1:0]  wr_addr_d;
  logic [d_width-1:0]  wr_data_d;
  logic [d_width-1:0]  regs [num_regs];
`ifdef SPI_ADDR_AUTOINC_EN
  logic                bound_q, bound_d;
`endif

  function automatic logic is_mapped(input logic [a_width-1:0] a);
    return int'(a) < num_regs;
  endfunction

  function automatic logic [d_width-1:0] reg_value(input logic [a_width-1:0] a);
    return is_mapped(a) ? regs[a[IW-1:0]] : '0;
  endfunction

  assign lcl_rdata = reg_value(lcl_addr);
  assign sdio      = oe_q ? sdo_q : 1'bz;

  // Frame decoder; an early cs release outranks any sclk edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    sdo_d     = sdo_q;
    err_d     = frame_err;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
`ifdef SPI_ADDR_AUTOINC_EN
    bound_d   = sclk_rise ? 1'b0 : bound_q;
`endif
    if (cs_rise && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
      if (!bound_q) err_d = 1'b1;
`else
      err_d   = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
          bound_d = 1'b0;
`endif
          if (!cs_s && !sclk_s) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rw_d    = sdi;
            cnt_d   = CNT_A;
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_d = {addr_q[a_width-2:0], sdi};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              cnt_d = CNT_D;
              if (rw_q == SPI_RW_READ) begin
                shift_d = reg_value(addr_d);
                state_d = ST_RDATA;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            shift_d = {shift_q[d_width-2:0], sdi};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              if (is_mapped(addr_q)) begin
                stb_d     = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = shift_d;
              end
`ifdef SPI_ADDR_AUTOINC_EN
              addr_d  = addr_q + 1'b1;
              cnt_d   = CNT_D;
              bound_d = 1'b1;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
        ST_RDATA: begin
          // The shift register is reloaded on the word's final rise so the next MSB is ready for the following fall.
          if (sclk_fall && cnt_q != '0) begin
            oe_d    = 1'b1;
            sdo_d   = shift_q[d_width-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
          end else if (sclk_rise && cnt_q == '0) begin
`ifdef SPI_ADDR_AUTOINC_EN
            addr_d  = addr_q + 1'b1;
            shift_d = reg_value(addr_d);
            cnt_d   = CNT_D;
            bound_d = 1'b1;
`else
            state_d = ST_DONE;
            oe_d    = 1'b0;
`endif
          end
        end
        ST_DONE: begin
          oe_d = 1'b0;
          if (cs_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rw_q      <= SPI_RW_WRITE;
      oe_q      <= 1'b0;
      sdo_q     <= 1'b0;
      frame_err <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < num_regs; i++) regs[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      sdo_q     <= sdo_d;
      frame_err <= err_d;
      wr_stb    <= stb_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      if (stb_d) regs[wr_addr_d[IW-1:0]] <= wr_data_d;
    end
  end

`ifdef SPI_ADDR_AUTOINC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bound_q <= 1'b0;
    else      bound_q <= bound_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         busy <= 1'b0;
    else if (cs_fall) busy <= 1'b1;
    else if (cs_rise) busy <= 1'b0;
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: acts as the SPI master and compares
// against an array model of the register file. Burst cases need SPI_ADDR_AUTOINC_EN.
module tb_spi_slave_regfile;

  localparam int  AW = 8;
  localparam int  DW = 16;
  localparam int  NR = 16;
  localparam time CLK_HALF   = 5;
  localparam time CLK_PERIOD = 10;
  localparam time SCLK_HALF  = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic m_oe = 1'b0;
  logic m_out = 1'b0;
  wire  sdio;
  logic [AW-1:0] lcl_addr = '0;
  logic [DW-1:0] lcl_rdata;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_err;

  assign sdio = m_oe ? m_out : 1'bz;
  pullup (sdio);

  spi_slave_regfile #(.a_width(AW), .d_width(DW), .num_regs(NR)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdio(sdio),
    .lcl_addr(lcl_addr), .lcl_rdata(lcl_rdata), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_err(frame_err)
  );

  always #(CLK_HALF) clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stb_count = 0;
  logic          busy_seen;
  logic [DW-1:0] model [NR];
  logic [AW-1:0] exp_wr_addr;
  logic [DW-1:0] exp_wr_data;
  logic [DW-1:0] tx_words [4];
  logic [DW-1:0] rx_words [4];

  always @(negedge clk) if (wr_stb) stb_count++;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic mapped(input logic [AW-1:0] a);
    return int'(a) < NR;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return mapped(a) ? model[a[3:0]] : 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
  endtask

  // Returns how many write strobes the model expects from this word.
  function automatic int model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!mapped(a)) return 0;
    model[a[3:0]] = d;
    exp_wr_addr = a;
    exp_wr_data = d;
    return 1;
  endfunction

  task automatic send_bit(input logic b);
    m_oe = 1'b1;
    m_out = b;
    #(SCLK_HALF) sclk = 1'b1;
    #(SCLK_HALF) sclk = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0;
    #(SCLK_HALF);
    b = sdio;
    sclk = 1'b1;
    #(SCLK_HALF) sclk = 1'b0;
  endtask

  task automatic frame_begin(input logic rw, input logic [AW-1:0] addr);
    cs = 1'b0;
    #(SCLK_HALF);
    busy_seen = busy;
    send_bit(rw);
    for (int i = AW - 1; i >= 0; i--) send_bit(addr[i]);
  endtask

  task automatic frame_end();
    m_oe = 1'b0;
    #(SCLK_HALF) cs = 1'b1;
    #(10 * CLK_PERIOD);
  endtask

  task automatic spi_write(input logic [AW-1:0] addr, input int nwords, input int extra);
    frame_begin(1'b0, addr);
    for (int w = 0; w < nwords; w++)
      for (int i = DW - 1; i >= 0; i--) send_bit(tx_words[w][i]);
    for (int k = 0; k < extra; k++) send_bit(1'b0);
    frame_end();
  endtask

  task automatic spi_read(input logic [AW-1:0] addr, input int nwords);
    logic b;
    frame_begin(1'b1, addr);
    for (int w = 0; w < nwords; w++)
      for (int i = DW - 1; i >= 0; i--) begin
        recv_bit(b);
        rx_words[w][i] = b;
      end
    frame_end();
  endtask

  task automatic check_lcl(input string tag, input logic [AW-1:0] a);
    lcl_addr = a;
    #1;
    check_output(tag, 32'(lcl_rdata), 32'(model_read(a)));
  endtask

  initial begin
    int s0;
    int exp_stb;
    logic b;
    logic [AW-1:0] ra;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_lcl_rdata", 32'(lcl_rdata), 32'h0);
    check_output("rst_wr_stb", 32'(wr_stb), 32'h0);
    check_output("rst_wr_addr", 32'(wr_addr), 32'h0);
    check_output("rst_wr_data", 32'(wr_data), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_frame_err", 32'(frame_err), 32'h0);
    check_output("rst_sdio_released", 32'(sdio), 32'h1);
    rst = 1'b1;
    #(5 * CLK_PERIOD);

    $display("[TB] write 0x3A5C to 0x05 and read it back");
    tx_words[0] = 16'h3A5C;
    s0 = stb_count;
    spi_write(8'h05, 1, 0);
    exp_stb = model_write(8'h05, 16'h3A5C);
    check_output("busy_in_frame", 32'(busy_seen), 32'h1);
    check_output("busy_after_frame", 32'(busy), 32'h0);
    check_output("w05_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    check_output("w05_wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
    check_output("w05_wr_data", 32'(wr_data), 32'(exp_wr_data));
    spi_read(8'h05, 1);
    check_output("r05_sdio_data", 32'(rx_words[0]), 32'(model_read(8'h05)));
    check_lcl("lcl_05", 8'h05);

    $display("[TB] unmapped address 0x20");
    spi_read(8'h20, 1);
    check_output("r20_sdio_data", 32'(rx_words[0]), 32'h0);
    tx_words[0] = 16'hFFFF;
    s0 = stb_count;
    spi_write(8'h20, 1, 0);
    exp_stb = model_write(8'h20, 16'hFFFF);
    check_output("w20_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    check_output("w20_wr_addr_kept", 32'(wr_addr), 32'(exp_wr_addr));
    check_lcl("lcl_20", 8'h20);

`ifndef SPI_ADDR_AUTOINC_EN
    $display("[TB] trailing sclk pulses after a complete write");
    tx_words[0] = 16'h0F0F;
    s0 = stb_count;
    spi_write(8'h09, 1, 4);
    exp_stb = model_write(8'h09, 16'h0F0F);
    check_output("extra_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    check_output("extra_frame_err", 32'(frame_err), 32'h0);
    check_lcl("lcl_09", 8'h09);
`endif

    $display("[TB] randomized single-word traffic");
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        spi_read(ra, 1);
        check_output("rand_read", 32'(rx_words[0]), 32'(model_read(ra)));
      end else begin
        tx_words[0] = 16'($urandom);
        s0 = stb_count;
        spi_write(ra, 1, 0);
        exp_stb = model_write(ra, tx_words[0]);
        check_output("rand_stb_count", 32'(stb_count - s0), 32'(exp_stb));
        check_output("rand_wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        check_output("rand_wr_data", 32'(wr_data), 32'(exp_wr_data));
      end
      check_lcl("rand_lcl", 8'($urandom_range(0, 31)));
    end
    check_output("rand_frame_err", 32'(frame_err), 32'h0);

    $display("[TB] aborted write to 0x02 after 6 data bits");
    tx_words[0] = 16'h1234;
    spi_write(8'h02, 1, 0);
    exp_stb = model_write(8'h02, 16'h1234);
    s0 = stb_count;
    tx_words[0] = 16'hABCD;
    frame_begin(1'b0, 8'h02);
    for (int i = DW - 1; i >= DW - 6; i--) send_bit(tx_words[0][i]);
    frame_end();
    check_output("abort_stb_count", 32'(stb_count - s0), 32'h0);
    check_lcl("abort_lcl_02", 8'h02);
    check_output("abort_frame_err", 32'(frame_err), 32'h1);
    check_output("abort_sdio_released", 32'(sdio), 32'h1);

    $display("[TB] reset asserted in the middle of a read");
    tx_words[0] = 16'h8000;
    spi_write(8'h03, 1, 0);
    exp_stb = model_write(8'h03, 16'h8000);
    frame_begin(1'b1, 8'h03);
    recv_bit(b);
    check_output("midread_first_bit", 32'(b), 32'h1);
    for (int i = 0; i < 3; i++) recv_bit(b);
    #(4 * CLK_PERIOD);
    check_output("midread_driving_zero", 32'(sdio), 32'h0);
    rst = 1'b0;
    model_reset();
    #1;
    check_output("midreset_sdio_released", 32'(sdio), 32'h1);
    check_output("midreset_wr_stb", 32'(wr_stb), 32'h0);
    check_output("midreset_wr_addr", 32'(wr_addr), 32'h0);
    check_output("midreset_wr_data", 32'(wr_data), 32'h0);
    check_output("midreset_busy", 32'(busy), 32'h0);
    check_output("midreset_frame_err", 32'(frame_err), 32'h0);
    check_lcl("midreset_lcl_03", 8'h03);
    m_oe = 1'b0;
    cs = 1'b1;
    #(5 * CLK_PERIOD);
    rst = 1'b1;
    #(5 * CLK_PERIOD);
    tx_words[0] = 16'hBEEF;
    s0 = stb_count;
    spi_write(8'h03, 1, 0);
    exp_stb = model_write(8'h03, 16'hBEEF);
    check_output("postreset_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    spi_read(8'h03, 1);
    check_output("postreset_read", 32'(rx_words[0]), 32'(model_read(8'h03)));
    check_output("postreset_frame_err", 32'(frame_err), 32'h0);

`ifdef SPI_ADDR_AUTOINC_EN
    $display("[TB] auto-increment bursts");
    tx_words[0] = 16'h1111;
    tx_words[1] = 16'h2222;
    s0 = stb_count;
    spi_write(8'h0E, 2, 0);
    exp_stb = model_write(8'h0E, 16'h1111) + model_write(8'h0F, 16'h2222);
    check_output("burst_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    check_output("burst_frame_err", 32'(frame_err), 32'h0);
    check_lcl("burst_lcl_0e", 8'h0E);
    check_lcl("burst_lcl_0f", 8'h0F);
    spi_read(8'h0E, 2);
    check_output("burst_read_w0", 32'(rx_words[0]), 32'(model_read(8'h0E)));
    check_output("burst_read_w1", 32'(rx_words[1]), 32'(model_read(8'h0F)));
    tx_words[0] = 16'hAAAA;
    tx_words[1] = 16'h5555;
    s0 = stb_count;
    spi_write(8'hFF, 2, 0);
    exp_stb = model_write(8'hFF, 16'hAAAA) + model_write(8'(9'h0FF + 9'h001), 16'h5555);
    check_output("wrap_stb_count", 32'(stb_count - s0), 32'(exp_stb));
    check_output("wrap_wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
    check_lcl("wrap_lcl_00", 8'h00);
    check_output("wrap_frame_err", 32'(frame_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
